bfu_pipe: RTL and testbench
===========================

BFU_PIPE -- requirements
Module: bfu_pipe

Interface
REQ-001 SHALL have parameter W, default 16: data width of g/h/x/y components, signed two's complement.
REQ-002 SHALL have parameter TW, default 16: twiddle component width, signed Q1.(TW-1).
REQ-003 SHALL have parameter TAGW, default 4: width of the opaque sideband tag carried with each sample.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1: input handshake; transfer when both are high.
REQ-007 SHALL have ports g_real, g_imag, h_real, h_imag  input  W  butterfly operands.
REQ-008 SHALL have ports tw_real, tw_imag  input  TW  twiddle factor.
REQ-009 SHALL have port inverse  input  1  use conj(tw), for IFFT.
REQ-010 SHALL have port scale  input  1  divide results by 2 with rounding.
REQ-011 SHALL have ports in_tag input TAGW and out_tag output TAGW: tag passed through unchanged with its sample.
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1: output handshake.
REQ-013 SHALL have ports x_real, x_imag, y_real, y_imag  output  W  x = g + h*w, y = g - h*w.
REQ-014 SHALL have ports ovf output 1 (sticky saturation flag) and ovf_clr input 1 (clears ovf).

Function
REQ-015 SHALL be a 3-stage pipeline: S1 registers the operands, S2 registers the four full-precision products, S3 registers the final results; latency is exactly 3 cycles with no stall.
REQ-016 SHALL advance all stages only on enable = !out_valid || out_ready; in_ready = enable; bubbles propagate as valid=0.
REQ-017 SHALL hold all stage contents and outputs stable while enable=0, and SHALL never drop, duplicate or reorder samples.
REQ-018 SHALL sample inverse, scale and in_tag together with the data, so that per-sample mode changes take effect without a flush.
REQ-019 SHALL form the products hr*wr, hi*wi, hr*wi, hi*wr at W+TW bits, with no truncation before S3.
REQ-020 SHALL compute, for inverse=0, t_r = hr*wr - hi*wi and t_i = hr*wi + hi*wr; for inverse=1, t_r = hr*wr + hi*wi and t_i = hi*wr - hr*wi.
REQ-021 SHALL rescale t by adding 2^(TW-2) and then arithmetic-shifting right by TW-1 (round half up), keeping W+2 bits.
REQ-022 SHALL form g±t in W+2 bits; when scale=1, SHALL add 1 and then arithmetic-shift right by 1.
REQ-023 SHALL saturate each of the four results to [-2^(W-1), 2^(W-1)-1].
REQ-024 SHALL set ovf on the S3 load of any saturating component; ovf stays set until ovf_clr=1; when set and clear coincide, set wins.

Reset
REQ-025 SHALL, while reset=0 at a clock edge, clear all stage valid bits, out_valid, ovf, out_tag and x/y outputs to 0.
REQ-026 SHALL discard in-flight samples on reset mid-operation; in_ready is 1 in the first cycle after reset.
REQ-027 SHALL not rely on data-path register reset for correctness beyond REQ-025.

Structure
REQ-028 SHALL take default widths, the rounding-constant and saturation helper functions, and a bfu_mode_t struct {inverse, scale} from shared package bfu_pkg.
REQ-029 SHALL instantiate sub-module cmult (parametrised W/TW, four registered signed products, enable input) for S2.

Verification
REQ-030 SHALL pass this scenario: g=(100,0), h=(200,0), tw=(32767,0), inverse=0, scale=0 -> 3 cycles later x=(300,0), y=(-100,0), ovf=0.
REQ-031 SHALL pass this scenario: g=(0,0), h=(200,0), tw=(0,-32768), inverse=0 -> x=(0,-200), y=(0,200); same with inverse=1 -> x=(0,200), y=(0,-200).
REQ-032 SHALL pass this scenario: g=h=(32767,0), tw=(32767,0), scale=0 -> x=(32767,0) saturated, y=(1,0), ovf=1 next cycle; ovf_clr pulse -> ovf=0.
REQ-033 SHALL pass this scenario: the same operands as REQ-032 with scale=1 -> x=(32767,0), y=(1,0), ovf stays 0.
REQ-034 SHALL pass this scenario: stream tags 0..7 back-to-back with out_ready toggled randomly -> tags emerge 0..7 in order, results match a golden model, and outputs stay stable while out_valid=1 and out_ready=0.
REQ-035 SHALL pass this scenario: reset=0 for one cycle with 3 samples in flight -> out_valid=0 and ovf=0 on the following cycle, and none of the 3 samples is ever emitted.

Source files
------------

// File: rtl/bfu_pkg.sv
// bfu_pkg -- shared definitions for the radix-2 butterfly pipeline.
//   BFU_W / BFU_TW / BFU_TAGW : default data, twiddle and tag widths
//   bfu_mode_t                : per-sample mode bits {inverse, scale}
//   rnd_const()               : round-half-up constant for a Q1.(tw-1) rescale
//   sat_clip() / sat_hit()    : clamp to a signed w-bit range / detect clamping
package bfu_pkg;

    localparam int BFU_W    = 16;
    localparam int BFU_TW   = 16;
    localparam int BFU_TAGW = 4;

    typedef struct packed {
        logic inverse;   // multiply by conj(tw)
        logic scale;     // halve the results with rounding
    } bfu_mode_t;

    // Half of one LSB after a right shift by (tw-1).
    function automatic logic signed [63:0] rnd_const(input int tw);
        return 64'sd1 <<< (tw - 2);
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int               w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] v,
                                     input int               w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/bfu_pipe_cmult.sv
// cmult -- registered signed partial products of h*w for the butterfly.
//   clk             : clock
//   en              : load enable (pipeline advance)
//   a_real, a_imag  : W-bit signed operand h
//   b_real, b_imag  : TW-bit signed operand w
//   p_rr/p_ii/p_ri/p_ir : full-precision products ar*br, ai*bi, ar*bi, ai*br
module cmult
    import bfu_pkg::*;
#(
    parameter int W  = BFU_W,
    parameter int TW = BFU_TW
) (
    input  logic              clk,
    input  logic              en,
    input  logic [W-1:0]      a_real,
    input  logic [W-1:0]      a_imag,
    input  logic [TW-1:0]     b_real,
    input  logic [TW-1:0]     b_imag,
    output logic [W+TW-1:0]   p_rr,
    output logic [W+TW-1:0]   p_ii,
    output logic [W+TW-1:0]   p_ri,
    output logic [W+TW-1:0]   p_ir
);

    localparam int PW = W + TW;

    // NOTE: product registers carry no reset; their contents only matter
    // alongside a valid bit, which is reset elsewhere.
    always_ff @(posedge clk) begin
        if (en) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            p_rr <= PW'($signed(a_real)) * PW'($signed(b_real));
            p_ii <= PW'($signed(a_imag)) * PW'($signed(b_imag));
            p_ri <= PW'($signed(a_real)) * PW'($signed(b_imag));
            p_ir <= PW'($signed(a_imag)) * PW'($signed(b_real));
        end
    end

endmodule

// File: rtl/bfu_pipe.sv
// bfu_pipe -- 3-stage radix-2 butterfly: x = g + h*w, y = g - h*w.
//   clk, reset            : clock, synchronous active-low reset
//   in_valid / in_ready   : input handshake
//   g_*, h_*, tw_*        : operands (signed), twiddle in Q1.(TW-1)
//   inverse, scale        : per-sample mode (conj twiddle, halve result)
//   in_tag / out_tag      : opaque sideband travelling with each sample
//   out_valid / out_ready : output handshake
//   x_*, y_*              : saturated results
//   ovf / ovf_clr         : sticky saturation flag and its clear
// Stages: S1 operands, S2 products (cmult), S3 results. The whole pipe
// advances together whenever the output register is free or being taken.
module bfu_pipe
    import bfu_pkg::*;
#(
    parameter int W    = BFU_W,
    parameter int TW   = BFU_TW,
    parameter int TAGW = BFU_TAGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    g_real,
    input  logic [W-1:0]    g_imag,
    input  logic [W-1:0]    h_real,
    input  logic [W-1:0]    h_imag,
    input  logic [TW-1:0]   tw_real,
    input  logic [TW-1:0]   tw_imag,
    input  logic            inverse,
    input  logic            scale,
    input  logic [TAGW-1:0] in_tag,
    output logic [TAGW-1:0] out_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    x_real,
    output logic [W-1:0]    x_imag,
    output logic [W-1:0]    y_real,
    output logic [W-1:0]    y_imag,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam int SW = W + TW + 1;   // sum of two products
    localparam int RW = W + 2;        // rescaled / butterfly width
    localparam logic signed [SW-1:0] RND = SW'(rnd_const(TW));
    localparam logic signed [RW-1:0] ONE = RW'(1);

    logic enable;
    assign enable   = !out_valid || out_ready;
    assign in_ready = enable;

    // ---------------- S1: operands ----------------
    logic            s1_valid;
    logic [W-1:0]    s1_g_r, s1_g_i, s1_h_r, s1_h_i;
    logic [TW-1:0]   s1_w_r, s1_w_i;
    bfu_mode_t       s1_mode;
    logic [TAGW-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (!reset)      s1_valid <= 1'b0;
        else if (enable) s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            s1_g_r          <= g_real;
            s1_g_i          <= g_imag;
            s1_h_r          <= h_real;
            s1_h_i          <= h_imag;
            s1_w_r          <= tw_real;
            s1_w_i          <= tw_imag;
            s1_mode.inverse <= inverse;
            s1_mode.scale   <= scale;
            s1_tag          <= in_tag;
        end
    end

    // ---------------- S2: products ----------------
    logic            s2_valid;
    logic [W-1:0]    s2_g_r, s2_g_i;
    bfu_mode_t       s2_mode;
    logic [TAGW-1:0] s2_tag;
    logic [W+TW-1:0] p_rr, p_ii, p_ri, p_ir;

    cmult #(.W(W), .TW(TW)) u_cmult (
        .clk    (clk),
        .en     (enable),
        .a_real (s1_h_r),
        .a_imag (s1_h_i),
        .b_real (s1_w_r),
        .b_imag (s1_w_i),
        .p_rr   (p_rr),
        .p_ii   (p_ii),
        .p_ri   (p_ri),
        .p_ir   (p_ir)
    );

    always_ff @(posedge clk) begin
        if (!reset)      s2_valid <= 1'b0;
        else if (enable) s2_valid <= s1_valid;
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            s2_g_r  <= s1_g_r;
            s2_g_i  <= s1_g_i;
            s2_mode <= s1_mode;
            s2_tag  <= s1_tag;
        end
    end

    // ---------------- S3 datapath (combinational) ----------------
    logic signed [SW-1:0] e_rr, e_ii, e_ri, e_ir;
    logic signed [SW-1:0] t_r_full, t_i_full;
    logic signed [RW-1:0] t_r, t_i, g_r_e, g_i_e;
    logic signed [RW-1:0] sum [4];
    logic signed [RW-1:0] pre [4];
    logic [W-1:0]         sat_v [4];
    logic [3:0]           hit;

    assign e_rr = SW'($signed(p_rr));
    assign e_ii = SW'($signed(p_ii));
    assign e_ri = SW'($signed(p_ri));
    assign e_ir = SW'($signed(p_ir));

    always_comb begin
        // NOTE: every always_comb output is assigned on all paths to avoid latches.
        t_r_full = e_rr - e_ii;
        t_i_full = e_ri + e_ir;
        if (s2_mode.inverse) begin
            // h * conj(w)
            t_r_full = e_rr + e_ii;
            t_i_full = e_ir - e_ri;
        end
    end

    // Round half up back to the data scale; the result always fits in RW bits.
    assign t_r   = RW'((t_r_full + RND) >>> (TW - 1));
    assign t_i   = RW'((t_i_full + RND) >>> (TW - 1));
    assign g_r_e = RW'($signed(s2_g_r));
    assign g_i_e = RW'($signed(s2_g_i));

    always_comb begin
        sum[0] = g_r_e + t_r;
        sum[1] = g_i_e + t_i;
        sum[2] = g_r_e - t_r;
        sum[3] = g_i_e - t_i;
        hit    = '0;
        for (int i = 0; i < 4; i++) begin
            pre[i]   = s2_mode.scale ? ((sum[i] + ONE) >>> 1) : sum[i];
            sat_v[i] = W'(sat_clip(64'(pre[i]), W));
            hit[i]   = sat_hit(64'(pre[i]), W);
        end
    end

    // ---------------- S3: results ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            x_real    <= '0;
            x_imag    <= '0;
            y_real    <= '0;
            y_imag    <= '0;
            ovf       <= 1'b0;
        end else begin
            if (enable) begin
                out_valid <= s2_valid;
                // Results hold their last valid sample across bubbles.
                if (s2_valid) begin
                    x_real  <= sat_v[0];
                    x_imag  <= sat_v[1];
                    y_real  <= sat_v[2];
                    y_imag  <= sat_v[3];
                    out_tag <= s2_tag;
                end
            end
            // A saturating load beats a simultaneous clear.
            if (enable && s2_valid && (|hit)) ovf <= 1'b1;
            else if (ovf_clr)                 ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bfu_pipe.sv
// tb_bfu_pipe -- self-checking bench for bfu_pipe: directed butterfly cases,
// ovf set/clear priority, randomized streaming with back-pressure against a
// behavioural model, and reset with samples in flight.
module tb_bfu_pipe;

    localparam int W    = 16;
    localparam int TW   = 16;
    localparam int TAGW = 4;
    localparam longint DMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint DMIN = -(longint'(1) << (W - 1));

    typedef struct {
        int g_r, g_i, h_r, h_i, w_r, w_i;
        bit inverse, scale;
        int tag;
    } stim_t;

    typedef struct {
        int x_r, x_i, y_r, y_i, tag;
        bit sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    g_real = '0, g_imag = '0, h_real = '0, h_imag = '0;
    logic [TW-1:0]   tw_real = '0, tw_imag = '0;
    logic            inverse = 1'b0, scale = 1'b0;
    logic [TAGW-1:0] in_tag = '0;
    logic [TAGW-1:0] out_tag;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    x_real, x_imag, y_real, y_imag;
    logic            ovf;
    logic            ovf_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_ovf  = 1'b0;
    stim_t stim_q[$];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    bfu_pipe #(.W(W), .TW(TW), .TAGW(TAGW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_real    (g_real),
        .g_imag    (g_imag),
        .h_real    (h_real),
        .h_imag    (h_imag),
        .tw_real   (tw_real),
        .tw_imag   (tw_imag),
        .inverse   (inverse),
        .scale     (scale),
        .in_tag    (in_tag),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_real    (x_real),
        .x_imag    (x_imag),
        .y_real    (y_real),
        .y_imag    (y_imag),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // ---------------- reference model ----------------
    function automatic longint fdiv(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint wi, tr, ti, one_lsb, half;
        longint v[4];
        one_lsb = longint'(1) << (TW - 1);
        half    = longint'(1) << (TW - 2);
        wi = s.inverse ? -longint'(s.w_i) : longint'(s.w_i);   // conj(w)
        tr = fdiv(longint'(s.h_r) * s.w_r - longint'(s.h_i) * wi + half, one_lsb);
        ti = fdiv(longint'(s.h_r) * wi + longint'(s.h_i) * s.w_r + half, one_lsb);
        v[0] = s.g_r + tr;
        v[1] = s.g_i + ti;
        v[2] = s.g_r - tr;
        v[3] = s.g_i - ti;
        e.sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s.scale) v[i] = fdiv(v[i] + 1, 2);
            if (v[i] > DMAX) begin v[i] = DMAX; e.sat = 1'b1; end
            if (v[i] < DMIN) begin v[i] = DMIN; e.sat = 1'b1; end
        end
        e.x_r = int'(v[0]);
        e.x_i = int'(v[1]);
        e.y_r = int'(v[2]);
        e.y_i = int'(v[3]);
        e.tag = s.tag;
        return e;
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic stim_t mk(input int gr, gi, hr, hi, wr, wi,
                                 input bit inv, sc, input int tag);
        stim_t s;
        s.g_r = gr; s.g_i = gi; s.h_r = hr; s.h_i = hi; s.w_r = wr; s.w_i = wi;
        s.inverse = inv; s.scale = sc; s.tag = tag;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        g_real  = W'(s.g_r);
        g_imag  = W'(s.g_i);
        h_real  = W'(s.h_r);
        h_imag  = W'(s.h_i);
        tw_real = TW'(s.w_r);
        tw_imag = TW'(s.w_i);
        inverse = s.inverse;
        scale   = s.scale;
        in_tag  = TAGW'(s.tag);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/ovf=%b, want 00", {out_valid, ovf});
        end
        n_checks++;
        if ({x_real, x_imag, y_real, y_imag, out_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 0", {x_real, x_imag, y_real, y_imag, out_tag});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    // One sample into an idle pipe; checks the 3-cycle latency and the result.
    task automatic run_one(input stim_t s, input int xr, xi, yr, yi,
                           input bit want_ovf, input string name);
        @(negedge clk);
        out_ready = 1'b1;
        drive(s);
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b, want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early: out_valid=%b after 2 cycles, want 0", name, out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid=%b after 3 cycles, want 1", name, out_valid);
        end
        n_checks++;
        if ({x_real, x_imag, y_real, y_imag} !== {W'(xr), W'(xi), W'(yr), W'(yi)}) begin
            n_fail++;
            $display("FAIL %s_data: got x=(%0d,%0d) y=(%0d,%0d), want x=(%0d,%0d) y=(%0d,%0d)",
                     name, $signed(x_real), $signed(x_imag), $signed(y_real), $signed(y_imag),
                     xr, xi, yr, yi);
        end
        n_checks++;
        if (ovf !== want_ovf) begin
            n_fail++;
            $display("FAIL %s_ovf: got %b, want %b", name, ovf, want_ovf);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic test_directed();
        run_one(mk(100, 0, 200, 0, 32767, 0, 0, 0, 1), 300, 0, -100, 0, 1'b0, "fwd_real");
        run_one(mk(0, 0, 200, 0, 0, -32768, 0, 0, 2), 0, -200, 0, 200, 1'b0, "fwd_minus_j");
        run_one(mk(0, 0, 200, 0, 0, -32768, 1, 0, 3), 0, 200, 0, -200, 1'b0, "inv_minus_j");
        run_one(mk(32767, 0, 32767, 0, 32767, 0, 0, 0, 4), 32767, 0, 1, 0, 1'b1, "sat_x");
        pulse_clr();
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, want 0", ovf);
        end
        run_one(mk(32767, 0, 32767, 0, 32767, 0, 0, 1, 5), 32767, 0, 1, 0, 1'b0, "scaled_no_sat");
    endtask

    // Clear asserted on the same edge a saturating sample loads S3.
    task automatic test_ovf_priority();
        pulse_clr();
        @(negedge clk);
        out_ready = 1'b1;
        drive(mk(32767, 0, 32767, 0, 32767, 0, 0, 0, 9));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, ovf} !== 2'b11) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got valid/ovf=%b, want 11", {out_valid, ovf});
        end
        @(negedge clk);
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr_after: got %b, want 0", ovf);
        end
    endtask

    // Streams stim_q through the DUT with optional random back-pressure.
    task automatic run_stream(input bit rand_ready, input string name);
        int n = stim_q.size();
        int idx = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [4*W+TAGW:0] held = '0;
        exp_t e;
        pulse_clr();
        exp_ovf = 1'b0;
        exp_q.delete();
        while ((idx < n || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < n) begin
                drive(stim_q[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall) begin
                n_checks++;
                if ({out_valid, x_real, x_imag, y_real, y_imag, out_tag} !== held) begin
                    n_fail++;
                    $display("FAIL %s_stable: got %h, want held %h", name,
                             {out_valid, x_real, x_imag, y_real, y_imag, out_tag}, held);
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_valid, x_real, x_imag, y_real, y_imag, out_tag};
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra: got unexpected sample tag %0d, want none", name, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (e.sat) exp_ovf = 1'b1;
                    if ({x_real, x_imag, y_real, y_imag, out_tag} !==
                        {W'(e.x_r), W'(e.x_i), W'(e.y_r), W'(e.y_i), TAGW'(e.tag)}) begin
                        n_fail++;
                        $display("FAIL %s_data: got x=(%0d,%0d) y=(%0d,%0d) tag=%0d, want x=(%0d,%0d) y=(%0d,%0d) tag=%0d",
                                 name, $signed(x_real), $signed(x_imag), $signed(y_real),
                                 $signed(y_imag), out_tag, e.x_r, e.x_i, e.y_r, e.y_i, e.tag);
                    end
                    n_checks++;
                    if (ovf !== exp_ovf) begin
                        n_fail++;
                        $display("FAIL %s_ovf: got %b, want %b (tag %0d)", name, ovf, exp_ovf, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(stim_q[idx]));
                idx++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (idx < n || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: sent %0d of %0d, %0d outstanding, want all done",
                     name, idx, n, exp_q.size());
        end
        stim_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            stim_q.push_back(mk(rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i));
        run_stream(1'b1, "tags0to7");
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 60; i++) begin
            // Smaller operands on even samples so not every result clamps.
            if (i % 2 == 0)
                stim_q.push_back(mk(rnd_s() / 4, rnd_s() / 4, rnd_s() / 4, rnd_s() / 4,
                                    rnd_s(), rnd_s(), 1'($urandom_range(0, 1)),
                                    1'($urandom_range(0, 1)), i % 16));
            else
                stim_q.push_back(mk(rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(),
                                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i % 16));
        end
        run_stream(1'b1, "random");
        for (int i = 0; i < 20; i++)
            stim_q.push_back(mk(rnd_s() / 4, rnd_s() / 4, rnd_s() / 4, rnd_s() / 4,
                                rnd_s(), rnd_s(), 1'(i % 2), 1'((i / 2) % 2), i % 16));
        run_stream(1'b0, "full_rate");
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(32767, 0, 32767, 0, 32767, 0, 0, 0, 5 + i));
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, ovf, in_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL midflight_full: got valid/ovf/ready=%b, want 110",
                     {out_valid, ovf, in_ready});
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, ovf, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midflight_reset: got valid/ovf/ready=%b, want 001",
                     {out_valid, ovf, in_ready});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midflight_flushed: got out_valid=1 after reset, want 0");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ovf_priority();
        test_back_to_back();
        test_random_stream();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
